// File: rtl/pipe_credit_sink_if.sv
// Handshake bundle for pipe_credit_sink: launch request/grant, pipeline arrival
// port and the valid/ready output toward the consumer.
interface pipe_credit_sink_if #(
    parameter int WIDTH = 16
);
    logic             issue_req;
    logic             issue_grant;
    logic             pipe_valid_in;
    logic [WIDTH-1:0] pipe_data_in;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;

    // master: the credit sink itself, which masters the m_* output stream
    modport master (
        input  issue_req,
        output issue_grant,
        input  pipe_valid_in,
        input  pipe_data_in,
        output m_valid,
        output m_data,
        input  m_ready
    );

    // slave: the surrounding producer pipeline and the consumer
    modport slave (
        output issue_req,
        input  issue_grant,
        output pipe_valid_in,
        output pipe_data_in,
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/pipe_credit_sink.sv
// Receiving end of a fixed-latency, non-stallable pipeline: grants launches
// against a credit pool and buffers arrivals in a FIFO with valid/ready output.
module pipe_credit_sink #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    pipe_credit_sink_if.master         bus,
    output logic [$clog2(DEPTH+1)-1:0] credits,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0]    r_credits;
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic             r_overflow;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_grant;
    logic             w_pop;
    logic             w_full;
    logic             w_push_acc;
    logic             w_drop;

    // Up/down counter step; both or neither event leaves the value unchanged.
    function automatic logic [CW-1:0] f_updown(input logic [CW-1:0] v,
                                               input logic          dec,
                                               input logic          inc);
        logic [CW-1:0] n;
        n = v;
        case ({dec, inc})
            2'b10:   n = v - CW'(1);
            2'b01:   n = v + CW'(1);
            default: n = v;
        endcase
        return n;
    endfunction

    assign w_grant    = bus.issue_req && (r_credits != '0);
    assign w_pop      = (r_count != '0) && bus.m_ready;
    assign w_full     = (r_count == CW'(DEPTH));
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push_acc = bus.pipe_valid_in && (!w_full || w_pop);
    assign w_drop     = bus.pipe_valid_in && w_full && !w_pop;

    assign bus.issue_grant = w_grant;
    assign bus.m_valid     = (r_count != '0);
    assign bus.m_data      = r_mem[r_rd_ptr];
    assign credits         = r_credits;
    assign count           = r_count;
    assign overflow        = r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits  <= CW'(DEPTH);
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_credits <= f_updown(r_credits, w_grant, w_pop);
            r_count   <= f_updown(r_count, w_pop, w_push_acc);
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage carries data only and is never reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= bus.pipe_data_in;
        end
    end
endmodule

// File: doc/pipe_credit_sink.md
Name: pipe_credit_sink

Overview:
- Receiving end of a fixed-latency, non-stallable valid/data pipeline.
- Issues launch grants to the upstream producer against a credit pool. The pool reserves FIFO space for every word still in flight.
- Buffers pipeline output in a FIFO and presents it on a valid/ready master port, so consumers can apply backpressure that the pipeline itself cannot.
- Sits between a processing-element pipeline's output and any backpressuring consumer (writeback, DMA, next PE).

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 8, FIFO entries and initial credit count; power of two, at least 2.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- issue_req  input  1  upstream requests to launch one word into the pipeline this cycle.
- issue_grant  output  1  combinational; equals issue_req && (credits != 0). Upstream launches only when this is high.
- pipe_valid_in  input  1  word arriving from the pipeline output.
- pipe_data_in  input  WIDTH  arriving word.
- m_valid  output  1  FIFO non-empty.
- m_data  output  WIDTH  head-of-FIFO word, valid when m_valid is high.
- m_ready  input  1  consumer accepts the head word.
- credits  output  $clog2(DEPTH+1)  free slots not yet reserved.
- count  output  $clog2(DEPTH+1)  FIFO occupancy.
- overflow  output  1  sticky error flag.

Behaviour:
- Reset: all of the following hold in the cycle after rst is sampled high, and reset wins over every other event that cycle.
  - credits=DEPTH, count=0.
  - Read and write pointers = 0.
  - m_valid=0, overflow=0.
  - m_data is don't-care.
  - issue_grant is 0 while credits would be 0; it is otherwise combinational and is not gated by rst.
- Reset mid-operation: words in flight in the upstream pipeline are the upstream's responsibility, because the pipeline shares the same reset.
- Definitions:
  - grant = issue_grant.
  - push = pipe_valid_in.
  - pop = m_valid && m_ready.
- Credit accounting, per cycle: credits_next = credits - grant + pop.
  - Simultaneous grant and pop leaves credits unchanged.
  - credits never exceeds DEPTH and never underflows, because grant requires credits != 0.
- Invariant when used correctly: credits + count + in-flight = DEPTH.
- FIFO:
  - Circular buffer with DEPTH entries.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count_next = count + push_accepted - pop.
- Push into a full FIFO:
  - If pop is high the same cycle, the push is accepted (a slot frees); count stays DEPTH.
  - If pop is low, the word is dropped and overflow is set. Pointers and count are unchanged.
- Push and pop on an empty FIFO: no bypass. The push is written and m_valid rises the next cycle; a pop with m_valid=0 does nothing.
- Timing:
  - m_valid = (count != 0).
  - m_data is a combinational read of the storage array at the read pointer.
  - Minimum latency from pipe_valid_in to m_valid is 1 cycle.
- Holding and ordering:
  - m_data holds stable while m_valid && !m_ready.
  - Words are delivered in arrival order; no reordering and no duplication.
- overflow clears only on rst.
- pipe_data_in is ignored when pipe_valid_in=0.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then all inputs 0.
  - Response: credits=8, count=0, m_valid=0, overflow=0. issue_req=1 yields issue_grant=1.
- Credit exhaustion:
  - Stimulus: issue_req=1 held 10 cycles, m_ready=0, pipeline modelled as 4-cycle delay.
  - Response: grants on exactly 8 cycles; credits reaches 0 and issue_grant=0 thereafter. Data 0x0001..0x0008 arrive, count=8, overflow=0.
- Drain and refill ordering:
  - Stimulus: from the full state, m_ready=1 for 3 cycles.
  - Response: m_data sequence 0x0001, 0x0002, 0x0003; credits=3, count=5.
  - Stimulus: then grant 3 more words 0x0009..0x000B.
  - Response: delivered after 0x0008 in order, across the pointer wrap.
- Simultaneous grant and pop:
  - Setup: count=4, credits=2, in-flight=2.
  - Stimulus: issue_req=1 and m_ready=1 for 1 cycle.
  - Response: credits stays 2, count=3 (if no arrival that cycle).
- Overflow on misuse:
  - Stimulus: FIFO full, inject pipe_valid_in=1 with data 0xDEAD and m_ready=0.
  - Response: overflow=1 (sticky), count=8, 0xDEAD never appears on m_data.
  - Stimulus: the same injection with m_ready=1.
  - Response: the word is accepted and appears last.
- Reset mid-stream:
  - Stimulus: count=5, credits=1, rst=1 for 1 cycle.
  - Response: count=0, credits=8, m_valid=0, overflow=0. The next pushed word 0x0042 emerges first.
